dot_arbiter: RTL and testbench
==============================

Name: dot_arbiter

Overview:
- Shares one dot_engine instance among NUM_REQ requesters.
- Each requester presents an A/B vector pair with a valid/ready handshake. The arbiter grants in round-robin order, registers the operands and issues them to the engine. It then collects the result and returns it on the granted requester's response channel.
- Exactly one transaction is outstanding at a time, because the engine only accepts input while idle.
- A watchdog aborts transactions the engine never completes.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_WIDTH, 8, signed element width of A.
- B_WIDTH, 8, signed element width of B.
- OUT_WIDTH, 18, signed result width; must match the engine.
- VEC_LEN, 4, elements per vector.
- TIMEOUT, 64, maximum cycles in WAIT before abort (≥ 2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester operand accept; one-hot or zero.
- req_a  in  NUM_REQ*VEC_LEN*A_WIDTH  packed A vectors; requester r element i at bits [(r*VEC_LEN+i)*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*VEC_LEN*B_WIDTH  packed B vectors; same packing as req_a.
- resp_valid  out  NUM_REQ  per-requester result valid; one-hot or zero.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_data  out  OUT_WIDTH  signed result; shared bus, meaningful where resp_valid is set.
- resp_err  out  1  qualifies resp_data: 1 = aborted by timeout, data = 0.
- eng_a  out  VEC_LEN x A_WIDTH  unpacked signed array to engine a.
- eng_b  out  VEC_LEN x B_WIDTH  unpacked signed array to engine b.
- eng_in_valid  out  1  engine in_valid.
- eng_in_ready  in  1  engine in_ready.
- eng_out_valid  in  1  engine out_valid.
- eng_out_ready  out  1  engine out_ready.
- eng_result  in  OUT_WIDTH  engine result.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high in every state except IDLE.
- txn_count  out  16  completed transactions, including aborted ones; wraps at 65535→0.
- timeout_flag  out  1  sticky; set on any abort, cleared only by reset.

Behaviour:
- Reset (reset==0 at posedge):
  - State to IDLE; rr_ptr=0; grant_id=0.
  - Operand and result registers cleared to 0.
  - All valid/ready outputs 0; busy=0; txn_count=0; timeout_flag=0.
  - Reset mid-transaction abandons it silently; no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Select g = first r with req_valid[r], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - If one exists, req_ready[g]=1 combinationally this cycle. On the edge: capture req_a/req_b slice g into operand registers, grant_id←g, go to ISSUE.
  - req_ready is never asserted outside IDLE.
- ISSUE:
  - eng_in_valid=1; eng_a/eng_b driven from registers and stable until handshake.
  - On eng_in_valid && eng_in_ready: go to WAIT and clear the watchdog counter.
- WAIT:
  - eng_out_ready=1.
  - On eng_out_valid: result_reg←eng_result, err←0, go to RESP.
  - Otherwise the watchdog increments. When the watchdog reaches TIMEOUT-1 with no eng_out_valid: result_reg←0, err←1, timeout_flag←1, go to RESP.
  - eng_out_valid arriving on that same cycle wins: normal completion, no error.
- RESP:
  - resp_valid[grant_id]=1; resp_data=result_reg; resp_err=err.
  - On resp_ready[grant_id]: txn_count++, rr_ptr←grant_id+1 (mod NUM_REQ), go to IDLE.
  - resp_ready of other requesters is ignored.
- Minimum latency from req accept to resp_valid: 2 + engine latency cycles. The next grant can occur the cycle after the response handshake.
- Fairness: a requester that holds req_valid is granted within NUM_REQ transactions.
- Operand registers hold the last issued values outside ISSUE.
- eng_out_valid seen in IDLE, ISSUE or RESP is ignored; eng_out_ready=0 in those states.
- Arithmetic: the block does none. Values pass through and are sign-preserved at the declared widths.

Test Plan:
- Single requester: reset released; req 0 sends a={1,2,3,4}, b={5,6,7,8} → req_ready[0] pulses one cycle; resp_valid[0] with resp_data=70, resp_err=0; txn_count=1.
- Round-robin contention:
  - All 4 req_valid held high; requester r sends a={r+1,0,0,0}, b={2,0,0,0}.
  - Required: grants in order 0,1,2,3,0; resp_data values 2,4,6,8; req_ready never multi-hot.
- Signed extremes: a={-128,-128,-128,-128}, b={-128,-128,-128,-128} → resp_data=65536. a={-128,…}, b={127,…} → resp_data=-65024.
- Response backpressure: resp_ready[1] held low 10 cycles.
  - resp_valid[1] and resp_data stay stable.
  - No new req_ready while busy; completion on release.
- Timeout: stub engine never asserts out_valid; TIMEOUT=64.
  - resp_valid rises 64 cycles after ISSUE→WAIT with resp_err=1 and resp_data=0.
  - timeout_flag=1 persists across later good transactions.
  - A companion case asserts eng_out_valid on exactly the TIMEOUT-1 cycle and requires normal completion, resp_err=0.
- Reset mid-WAIT: reset=0 for one cycle during WAIT → all outputs at reset values next cycle; no resp_valid; txn_count=0; rr_ptr=0, so requester 0 is granted first afterwards.

Source files
------------

// File: rtl/dot_arbiter.sv
// Round-robin arbiter sharing one dot-product engine among NUM_REQ requesters.
// One transaction in flight; a watchdog aborts engine calls that never return.
module dot_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 18,
    parameter int VEC_LEN   = 4,
    parameter int TIMEOUT   = 64,
    localparam int GW       = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*VEC_LEN*A_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*VEC_LEN*B_WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]                   resp_valid,
    input  logic [NUM_REQ-1:0]                   resp_ready,
    output logic signed [OUT_WIDTH-1:0]          resp_data,
    output logic                                 resp_err,
    output logic signed [A_WIDTH-1:0]            eng_a [VEC_LEN],
    output logic signed [B_WIDTH-1:0]            eng_b [VEC_LEN],
    output logic                                 eng_in_valid,
    input  logic                                 eng_in_ready,
    input  logic                                 eng_out_valid,
    output logic                                 eng_out_ready,
    input  logic signed [OUT_WIDTH-1:0]          eng_result,
    output logic [GW-1:0]                        grant_id,
    output logic                                 busy,
    output logic [15:0]                          txn_count,
    output logic                                 timeout_flag
);

    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                       state;
    logic [GW-1:0]                rr_ptr;
    logic [WW-1:0]                wd;
    logic signed [OUT_WIDTH-1:0]  result_reg;
    logic                         err_reg;
    logic signed [A_WIDTH-1:0]    a_reg [VEC_LEN];
    logic signed [B_WIDTH-1:0]    b_reg [VEC_LEN];
    logic [GW-1:0]                sel;
    logic                         found;

    // Pick the first valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        logic [GW:0] idx;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr} + (GW + 1)'(i);
            if (idx >= (GW + 1)'(NUM_REQ)) begin
                idx = idx - (GW + 1)'(NUM_REQ);
            end
            if (req_valid[idx[GW-1:0]]) begin
                sel   = idx[GW-1:0];
                found = 1'b1;
            end
        end
    end

    // Handshake strobes decoded from the registered state.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if (reset && state == S_IDLE && found) begin
            req_ready[sel] = 1'b1;
        end
        if (state == S_RESP) begin
            resp_valid[grant_id] = 1'b1;
        end
    end

    assign eng_in_valid  = (state == S_ISSUE);
    assign eng_out_ready = (state == S_WAIT);
    assign busy          = (state != S_IDLE);
    assign resp_data     = result_reg;
    assign resp_err      = err_reg;
    assign eng_a         = a_reg;
    assign eng_b         = b_reg;

    // Transaction FSM: grant, issue, wait with watchdog, respond.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            grant_id     <= '0;
            wd           <= '0;
            result_reg   <= '0;
            err_reg      <= 1'b0;
            txn_count    <= '0;
            timeout_flag <= 1'b0;
            for (int i = 0; i < VEC_LEN; i++) begin
                a_reg[i] <= '0;
                b_reg[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        for (int i = 0; i < VEC_LEN; i++) begin
                            a_reg[i] <= req_a[(int'(sel) * VEC_LEN + i) * A_WIDTH +: A_WIDTH];
                            b_reg[i] <= req_b[(int'(sel) * VEC_LEN + i) * B_WIDTH +: B_WIDTH];
                        end
                        grant_id <= sel;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (eng_in_ready) begin
                        wd    <= '0;
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eng_out_valid) begin
                        result_reg <= eng_result;
                        err_reg    <= 1'b0;
                        state      <= S_RESP;
                    end else if (wd == WW'(TIMEOUT - 1)) begin
                        result_reg   <= '0;
                        err_reg      <= 1'b1;
                        timeout_flag <= 1'b1;
                        state        <= S_RESP;
                    end else begin
                        wd <= wd + WW'(1);
                    end
                end
                S_RESP: begin
                    if (resp_ready[grant_id]) begin
                        txn_count <= txn_count + 16'd1;
                        rr_ptr    <= (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + GW'(1);
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dot_arbiter.sv
// Bench for dot_arbiter: stub engine with programmable latency, scoreboard
// of expected responses, table vectors and multi-cycle corner sequences.
module tb_dot_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int BW = 8;
    localparam int OW = 18;
    localparam int VL = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0] req_valid, req_ready, resp_valid, resp_ready;
    logic [N*VL*AW-1:0] req_a;
    logic [N*VL*BW-1:0] req_b;
    logic signed [OW-1:0] resp_data;
    logic resp_err;
    logic signed [AW-1:0] eng_a [VL];
    logic signed [BW-1:0] eng_b [VL];
    logic eng_in_valid, eng_in_ready, eng_out_valid, eng_out_ready;
    logic signed [OW-1:0] eng_result;
    logic [1:0] grant_id;
    logic busy;
    logic [15:0] txn_count;
    logic timeout_flag;

    always #5 clk = ~clk;

    dot_arbiter #(
        .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW),
        .OUT_WIDTH(OW), .VEC_LEN(VL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .eng_a(eng_a), .eng_b(eng_b),
        .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready),
        .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready),
        .eng_result(eng_result),
        .grant_id(grant_id), .busy(busy),
        .txn_count(txn_count), .timeout_flag(timeout_flag)
    );

    // Stub engine: out_valid eng_lat cycles after input handshake.
    logic stub_busy = 1'b0;
    int   stub_cnt  = 0;
    int   stub_res  = 0;
    int   eng_lat   = 3;
    bit   eng_never = 1'b0;

    function automatic int dot_now();
        int s = 0;
        for (int i = 0; i < VL; i++) s += int'(eng_a[i]) * int'(eng_b[i]);
        return s;
    endfunction

    assign eng_in_ready  = !stub_busy;
    assign eng_out_valid = stub_busy && !eng_never && (stub_cnt >= eng_lat);
    assign eng_result    = OW'(stub_res);

    always @(posedge clk) begin
        if (!reset) begin
            stub_busy <= 1'b0;
        end else if (!stub_busy) begin
            if (eng_in_valid) begin
                stub_busy <= 1'b1;
                stub_cnt  <= 0;
                stub_res  <= dot_now();
            end
        end else if (!eng_out_ready || eng_out_valid) begin
            stub_busy <= 1'b0;
        end else begin
            stub_cnt <= stub_cnt + 1;
        end
    end

    typedef struct packed {
        logic [1:0]              r;
        logic [VL-1:0][AW-1:0]   a;
        logic [VL-1:0][BW-1:0]   b;
        int                      exp;
    } vec_t;

    typedef struct {
        int id;
        int data;
        bit err;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  exp_data [N];
    bit  exp_err = 1'b0;
    int  pend [N];
    bit  acc_now [N];
    int  grant_log [64];
    int  gcnt = 0;
    int  cyc = 0;
    int  acc_cyc = 0;
    int  rise_cyc = 0;
    int  resp_done = 0;
    bit  hold = 1'b0;
    logic [N-1:0] prev_rv = '0;
    logic signed [OW-1:0] prev_data = '0;
    bit  prev_err = 1'b0;

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic int onehot_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Monitor: invariants, scoreboard push on accept, pop on response.
    task automatic sample();
        sb_t e;
        int  g;
        for (int r = 0; r < N; r++) acc_now[r] = 1'b0;
        check("req_ready_onehot", int'($countones(req_ready) <= 1), 1);
        check("resp_valid_onehot", int'($countones(resp_valid) <= 1), 1);
        if (busy) check("req_ready_busy", int'(req_ready), 0);
        if (!reset) begin
            sb.delete();
            prev_rv = '0;
            hold = 1'b0;
            cyc++;
            return;
        end
        if ((req_valid & req_ready) != 0) begin
            g = onehot_idx(req_valid & req_ready);
            e.id = g;
            e.data = exp_data[g];
            e.err = exp_err;
            sb.push_back(e);
            acc_now[g] = 1'b1;
            grant_log[gcnt % 64] = g;
            gcnt++;
            acc_cyc = cyc;
        end
        if (resp_valid != 0) begin
            if (prev_rv == 0) rise_cyc = cyc;
            if (hold) begin
                check("resp_hold_valid", int'(resp_valid), int'(prev_rv));
                check("resp_hold_data", int'(resp_data), int'(prev_data));
                check("resp_hold_err", int'(resp_err), int'(prev_err));
            end
            if ((resp_valid & resp_ready) != 0) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", int'(resp_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", onehot_idx(resp_valid), e.id);
                    check("resp_data", int'(resp_data), e.data);
                    check("resp_err", int'(resp_err), int'(e.err));
                end
                resp_done++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
            end
        end else begin
            hold = 1'b0;
        end
        prev_rv = resp_valid;
        prev_data = resp_data;
        prev_err = resp_err;
        cyc++;
    endtask

    // One clock: sample at negedge, update drives 1 time unit after posedge.
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (acc_now[r]) begin
                pend[r]--;
                if (pend[r] <= 0) req_valid[r] = 1'b0;
            end
        end
    endtask

    task automatic load(int r, logic [VL-1:0][AW-1:0] a,
                        logic [VL-1:0][BW-1:0] b, int exp, int n);
        for (int i = 0; i < VL; i++) begin
            req_a[(r * VL + i) * AW +: AW] = a[i];
            req_b[(r * VL + i) * BW +: BW] = b[i];
        end
        exp_data[r] = exp;
        pend[r] = n;
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_done(int target, int budget, string name);
        int k = 0;
        while (resp_done < target && k < budget) begin
            tick();
            k++;
        end
        check(name, int'(resp_done >= target), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1);
    end

    initial begin
        vec_t tab [6];
        int   base;
        int   g0;

        tab[0] = '{r: 2'd0, a: {8'd4, 8'd3, 8'd2, 8'd1},
                   b: {8'd8, 8'd7, 8'd6, 8'd5}, exp: 70};
        tab[1] = '{r: 2'd1, a: {8'h80, 8'h80, 8'h80, 8'h80},
                   b: {8'h80, 8'h80, 8'h80, 8'h80}, exp: 65536};
        tab[2] = '{r: 2'd2, a: {8'h80, 8'h80, 8'h80, 8'h80},
                   b: {8'h7f, 8'h7f, 8'h7f, 8'h7f}, exp: -65024};
        tab[3] = '{r: 2'd3, a: {8'd4, 8'hfd, 8'd2, 8'hff},
                   b: {8'hf8, 8'd7, 8'hfa, 8'd5}, exp: -70};
        tab[4] = '{r: 2'd1, a: {8'h7f, 8'h7f, 8'h7f, 8'h7f},
                   b: {8'h7f, 8'h7f, 8'h7f, 8'h7f}, exp: 64516};
        tab[5] = '{r: 2'd0, a: {8'd0, 8'd0, 8'd0, 8'd0},
                   b: {8'h80, 8'h80, 8'h80, 8'h80}, exp: 0};

        reset = 1'b0;
        req_valid = '0;
        resp_ready = '1;
        req_a = '0;
        req_b = '0;
        for (int r = 0; r < N; r++) begin
            pend[r] = 0;
            exp_data[r] = 0;
        end
        repeat (2) tick();
        req_valid = 4'b0001;
        tick();
        check("rst_req_ready", int'(req_ready), 0);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_valid", int'(eng_in_valid), 0);
        check("rst_out_ready", int'(eng_out_ready), 0);
        check("rst_txn_count", int'(txn_count), 0);
        check("rst_timeout_flag", int'(timeout_flag), 0);
        check("rst_grant_id", int'(grant_id), 0);
        check("rst_resp_data", int'(resp_data), 0);
        check("rst_resp_err", int'(resp_err), 0);
        check("rst_eng_a0", int'(eng_a[0]), 0);
        req_valid = '0;
        reset = 1'b1;

        for (int t = 0; t < 6; t++) begin
            base = resp_done;
            load(int'(tab[t].r), tab[t].a, tab[t].b, tab[t].exp, 1);
            wait_done(base + 1, 40, "table_done");
            check("table_latency", rise_cyc - acc_cyc, 6);
            check("table_txn_count", int'(txn_count), t + 1);
            check("table_grant", int'(grant_id), int'(tab[t].r));
        end

        reset = 1'b0;
        tick();
        reset = 1'b1;
        base = resp_done;
        g0 = gcnt;
        for (int r = 0; r < N; r++) begin
            load(r, {8'd0, 8'd0, 8'd0, 8'(r + 1)}, {8'd0, 8'd0, 8'd0, 8'd2},
                 2 * (r + 1), (r == 0) ? 2 : 1);
        end
        wait_done(base + 5, 200, "rr_done");
        for (int k = 0; k < 5; k++) begin
            check("rr_grant", grant_log[(g0 + k) % 64], k % 4);
        end
        check("rr_txn_count", int'(txn_count), 5);

        base = resp_done;
        resp_ready = 4'b1101;
        load(1, {8'd1, 8'd1, 8'd1, 8'd1}, {8'd3, 8'd3, 8'd3, 8'd3}, 12, 1);
        for (int k = 0; k < 40 && resp_valid[1] == 1'b0; k++) tick();
        check("bp_resp_valid", int'(resp_valid), 2);
        g0 = gcnt;
        load(2, {8'd0, 8'd0, 8'd9, 8'd0}, {8'd0, 8'd0, 8'hfe, 8'd0}, -18, 1);
        repeat (10) tick();
        check("bp_no_grant", gcnt - g0, 0);
        check("bp_still_valid", int'(resp_valid), 2);
        check("bp_data", int'(resp_data), 12);
        check("bp_txn_count", int'(txn_count), 5);
        resp_ready = '1;
        wait_done(base + 2, 60, "bp_done");
        check("bp_next_grant", grant_log[g0 % 64], 2);
        check("bp_txn_after", int'(txn_count), 7);

        base = resp_done;
        eng_never = 1'b1;
        exp_err = 1'b1;
        load(3, {8'd5, 8'd5, 8'd5, 8'd5}, {8'd5, 8'd5, 8'd5, 8'd5}, 0, 1);
        wait_done(base + 1, 120, "to_done");
        check("to_latency", rise_cyc - acc_cyc, TO + 2);
        check("to_flag", int'(timeout_flag), 1);

        eng_never = 1'b0;
        eng_lat = TO - 1;
        exp_err = 1'b0;
        load(0, tab[0].a, tab[0].b, 70, 1);
        wait_done(base + 2, 120, "to_edge_done");
        check("to_edge_latency", rise_cyc - acc_cyc, TO + 2);
        check("to_edge_flag", int'(timeout_flag), 1);

        eng_lat = 1;
        load(2, tab[1].a, tab[1].b, 65536, 1);
        wait_done(base + 3, 40, "to_good_done");
        check("to_good_latency", rise_cyc - acc_cyc, 4);
        check("to_good_flag", int'(timeout_flag), 1);

        eng_never = 1'b1;
        load(1, tab[0].a, tab[0].b, 70, 1);
        repeat (6) tick();
        check("mid_in_wait", int'(eng_out_ready), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_busy", int'(busy), 0);
        check("mid_resp_valid", int'(resp_valid), 0);
        check("mid_txn_count", int'(txn_count), 0);
        check("mid_timeout_flag", int'(timeout_flag), 0);
        check("mid_grant_id", int'(grant_id), 0);
        check("mid_out_ready", int'(eng_out_ready), 0);
        eng_never = 1'b0;
        eng_lat = 2;
        base = resp_done;
        g0 = gcnt;
        load(3, {8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd0, 8'd3}, 21, 1);
        load(0, {8'd0, 8'd0, 8'd0, 8'hff}, {8'd0, 8'd0, 8'd0, 8'd4}, -4, 1);
        wait_done(base + 2, 60, "post_rst_done");
        check("post_rst_first", grant_log[g0 % 64], 0);
        check("post_rst_second", grant_log[(g0 + 1) % 64], 3);
        check("post_rst_txn", int'(txn_count), 2);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
